// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl -- sequencing controller for one SHA-256 compression.
// Owns the 16-word message-schedule window and the round counter. Drives the
// strobes that tell the external adder datapath when to load a..h, run a round,
// and fold the result back into H.
// Optional build macro SHA_ROUND_STALL_EN adds the i_stall input, which freezes
// the ROUND and FINAL phases for as long as it is held.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [511:0] i_block,
  input  logic [31:0]  i_new_word,
`ifdef SHA_ROUND_STALL_EN
  input  logic         i_stall,
`endif
  output logic [511:0] o_words,
  output logic [5:0]   o_round,
  output logic         o_ready,
  output logic         o_load_state,
  output logic         o_round_en,
  output logic         o_final,
  output logic         o_done
);

  // Index of the last round. o_round stops here and never wraps past it.
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e       state_q;
  state_e       state_d;
  logic [511:0] words_q;
  logic [511:0] words_d;
  logic [5:0]   round_q;
  logic [5:0]   round_d;
  logic         stall_s;

`ifdef SHA_ROUND_STALL_EN
  assign stall_s = i_stall;
`else
  // Without the stall feature the controller behaves as if the stall is never raised.
  assign stall_s = 1'b0;
`endif

  // Next-state logic: capture the block on accept, shift the window each round.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // Slot 15 (top bits) receives W0, slot 0 receives W15.
          state_d = ST_LOAD;
          words_d = i_block;
          round_d = 6'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (stall_s) begin
          state_d = ST_ROUND;
        end else begin
          // Every slot moves one step toward slot 15; the fresh word enters slot 0.
          words_d = {words_q[479:0], i_new_word};
          if (round_q == LAST_ROUND) begin
            state_d = ST_FINAL;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
      end
      ST_FINAL: begin
        if (stall_s) begin
          state_d = ST_FINAL;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, window and round registers; reset abandons any block in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      words_q <= 512'd0;
      round_q <= 6'd0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      round_q <= round_d;
    end
  end

  // Strobe decode from the registered state; a stall masks the update strobes.
  always_comb begin
    o_ready      = 1'b0;
    o_load_state = 1'b0;
    o_round_en   = 1'b0;
    o_final      = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      ST_IDLE:  o_ready      = 1'b1;
      ST_LOAD:  o_load_state = 1'b1;
      ST_ROUND: o_round_en   = ~stall_s;
      ST_FINAL: o_final      = ~stall_s;
      ST_DONE:  o_done       = 1'b1;
      default:  o_ready      = 1'b0;
    endcase
  end

  assign o_words = words_q;
  assign o_round = round_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a 64-round and a 2-round instance share the
// stimulus and are both tracked by a phase/sequence model.
module tb_sha256_round_ctrl;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [511:0] block    = 512'd0;
  logic [31:0]  new_word = 32'd0;
  logic         stall_v  = 1'b0;
  logic         chk_en   = 1'b0;
  int           cyc      = 0;
  int           nvec     = 0;
  int           nmis     = 0;

  logic [511:0] words0, words1;
  logic [5:0]   round0, round1;
  logic         rdy0, ld0, ren0, fin0, dn0;
  logic         rdy1, ld1, ren1, fin1, dn1;
  logic [4:0]   ctl0, ctl1;
  assign ctl0 = {rdy0, ld0, ren0, fin0, dn0};
  assign ctl1 = {rdy1, ld1, ren1, fin1, dn1};

  logic [511:0] abc_blk;
  logic [31:0]  wabc [0:79];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_round_ctrl #(.ROUNDS(64)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_block(block), .i_new_word(new_word),
`ifdef SHA_ROUND_STALL_EN
    .i_stall(stall_v),
`endif
    .o_words(words0), .o_round(round0), .o_ready(rdy0), .o_load_state(ld0),
    .o_round_en(ren0), .o_final(fin0), .o_done(dn0)
  );

  sha256_round_ctrl #(.ROUNDS(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_block(block), .i_new_word(new_word),
`ifdef SHA_ROUND_STALL_EN
    .i_stall(stall_v),
`endif
    .o_words(words1), .o_round(round1), .o_ready(rdy1), .o_load_state(ld1),
    .o_round_en(ren1), .o_final(fin1), .o_done(dn1)
  );

  // ---------------- reference model ----------------
  // Per instance: busy flag, phase k since accept (0 = load, 1..R = round k-1,
  // R+1 = final, R+2 = done), and the full word sequence W0.. as seen so far.
  logic        m_busy [2];
  logic        m_zero [2];
  int          m_k    [2];
  logic [31:0] m_seq  [2][80];

  function automatic int rr(input int i);
    return (i == 0) ? 64 : 2;
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_zero[i] <= 1'b1;
        m_k[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (start) begin
            m_busy[i] <= 1'b1;
            m_zero[i] <= 1'b0;
            m_k[i]    <= 0;
            for (int j = 0; j < 16; j++) m_seq[i][j] <= block[511 - 32*j -: 32];
          end
        end else if (!(stall_v && m_k[i] >= 1 && m_k[i] <= rr(i) + 1)) begin
          if (m_k[i] >= 1 && m_k[i] <= rr(i)) m_seq[i][15 + m_k[i]] <= new_word;
          if (m_k[i] == rr(i) + 2) m_busy[i] <= 1'b0;
          else m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  function automatic logic [4:0] m_ctl(input int i);
    logic [4:0] c;
    c = 5'b10000;
    if (m_busy[i]) begin
      if (m_k[i] == 0)                 c = 5'b01000;
      else if (m_k[i] <= rr(i))        c = stall_v ? 5'b00000 : 5'b00100;
      else if (m_k[i] == rr(i) + 1)    c = stall_v ? 5'b00000 : 5'b00010;
      else                             c = 5'b00001;
    end
    return c;
  endfunction

  function automatic logic [5:0] m_round(input int i);
    int r;
    if (m_zero[i] || m_k[i] == 0) r = 0;
    else if (m_k[i] <= rr(i))     r = m_k[i] - 1;
    else                          r = rr(i) - 1;
    return 6'(r);
  endfunction

  function automatic logic [511:0] m_win(input int i);
    logic [511:0] w;
    int base;
    w = 512'd0;
    if (!m_zero[i]) begin
      if (m_k[i] == 0)             base = 0;
      else if (m_k[i] - 1 < rr(i)) base = m_k[i] - 1;
      else                         base = rr(i);
      for (int s = 0; s < 16; s++) w[32*s +: 32] = m_seq[i][base + 15 - s];
    end
    return w;
  endfunction

  task automatic check(input string name, input int inst, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctl", 0, {507'd0, ctl0}, {507'd0, m_ctl(0)});
      check("round", 0, {506'd0, round0}, {506'd0, m_round(0)});
      check("window", 0, words0, m_win(0));
      check("ctl", 1, {507'd0, ctl1}, {507'd0, m_ctl(1)});
      check("round", 1, {506'd0, round1}, {506'd0, m_round(1)});
      check("window", 1, words1, m_win(1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] lit64(input int off);
    return {(off == 0 || off >= 68), (off == 1), (off >= 2 && off <= 65), (off == 66), (off == 67)};
  endfunction

  function automatic logic [4:0] lit2(input int off);
    return {(off == 0 || off >= 6), (off == 1), (off == 2 || off == 3), (off == 4), (off == 5)};
  endfunction

  task automatic rand_block();
    for (int j = 0; j < 16; j++) block[32*j +: 32] = $urandom;
  endtask

  // One "abc" block on both instances with the true schedule on i_new_word.
  task automatic run_abc();
    next_cycle();
    start = 1'b1;
    block = abc_blk;
    for (int off = 0; off < 70; off++) begin
      if (off > 0) begin
        next_cycle();
        start = 1'b0;
      end
      new_word = (off >= 2 && off < 66) ? wabc[off + 14] : $urandom;
      @(negedge clk);
      check("abc_ctl64", 0, {507'd0, ctl0}, {507'd0, lit64(off)});
      check("abc_ctl2", 1, {507'd0, ctl1}, {507'd0, lit2(off)});
      if (off == 1)  check("abc_load_w0", 0, {480'd0, words0[511:480]}, {480'd0, 32'h61626380});
      if (off == 18) check("abc_w16", 0, {480'd0, words0[511:480]}, {480'd0, 32'h61626380});
      if (off == 19) check("abc_w17", 0, {480'd0, words0[511:480]}, {480'd0, 32'h000f0000});
      if (off >= 2 && off < 66) begin
        check("abc_wt", 0, {480'd0, words0[511:480]}, {480'd0, wabc[off - 2]});
        check("abc_t", 0, {506'd0, round0}, {506'd0, 6'(off - 2)});
      end
      if (off == 2 || off == 3) check("r2_t", 1, {506'd0, round1}, {506'd0, 6'(off - 2)});
    end
  endtask

  initial begin
    int loads;
    int dones;
    int cnt;
    int ld_at [3];

    abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    for (int j = 0; j < 16; j++) wabc[j] = abc_blk[511 - 32*j -: 32];
    for (int t = 16; t < 80; t++) begin
      wabc[t] = (ror(wabc[t-2], 17) ^ ror(wabc[t-2], 19) ^ (wabc[t-2] >> 10)) + wabc[t-7]
              + (ror(wabc[t-15], 7) ^ ror(wabc[t-15], 18) ^ (wabc[t-15] >> 3)) + wabc[t-16];
    end

    // Reset, then 100 idle cycles.
    repeat (3) next_cycle();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    for (int n = 0; n < 100; n++) begin
      next_cycle();
      new_word = $urandom;
      rand_block();
      @(negedge clk);
      check("idle_ctl", 0, {507'd0, ctl0}, {507'd0, 5'b10000});
      check("idle_words", 0, words0, 512'd0);
      check("idle_round", 0, {506'd0, round0}, 512'd0);
    end

    run_abc();

    // i_start held high continuously.
    next_cycle();
    start = 1'b1;
    block = abc_blk;
    loads = 0;
    dones = 0;
    for (int off = 0; off < 204; off++) begin
      if (off > 0) next_cycle();
      new_word = $urandom;
      @(negedge clk);
      if (ld0) begin
        if (loads < 3) ld_at[loads] = off;
        loads++;
      end
      if (dn0) dones++;
    end
    next_cycle();
    start = 1'b0;
    check("cont_loads", 0, 512'(loads), 512'd3);
    check("cont_dones", 0, 512'(dones), 512'd3);
    check("cont_acc1", 0, 512'(ld_at[1] - 1), 512'd68);
    check("cont_acc2", 0, 512'(ld_at[2] - 1), 512'd136);
    repeat (10) next_cycle();

    // Reset pulse while o_round = 30.
    next_cycle();
    start = 1'b1;
    rand_block();
    for (int off = 0; off < 32; off++) begin
      if (off > 0) begin
        next_cycle();
        start = 1'b0;
      end
      new_word = $urandom;
    end
    @(negedge clk);
    check("pre_reset_t", 0, {506'd0, round0}, {506'd0, 6'd29});
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_words", 0, words0, 512'd0);
    check("rst_ctl", 0, {507'd0, ctl0}, {507'd0, 5'b10000});
    check("rst_round", 0, {506'd0, round0}, 512'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 80; n++) begin
      next_cycle();
      @(negedge clk);
      if (fin0 || dn0 || ld0 || ren0) cnt++;
    end
    check("rst_no_strobes", 0, 512'(cnt), 512'd0);
    run_abc();

`ifdef SHA_ROUND_STALL_EN
    // Stall for 5 cycles at o_round = 10.
    next_cycle();
    start = 1'b1;
    block = abc_blk;
    for (int off = 0; off < 76; off++) begin
      if (off > 0) begin
        next_cycle();
        start = 1'b0;
      end
      stall_v  = (off >= 12 && off <= 16);
      new_word = $urandom;
      @(negedge clk);
      check("stall_ctl", 0, {507'd0, ctl0},
            {507'd0, (off == 0 || off >= 73), (off == 1),
             ((off >= 2 && off <= 11) || (off >= 17 && off <= 70)), (off == 71), (off == 72)});
      if (off >= 12 && off <= 17) check("stall_t", 0, {506'd0, round0}, {506'd0, 6'd10});
    end
    stall_v = 1'b0;
`endif

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      next_cycle();
      rst_n    = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      start    = ($urandom_range(0, 3) == 0);
      new_word = $urandom;
      rand_block();
`ifdef SHA_ROUND_STALL_EN
      stall_v  = ($urandom_range(0, 4) == 0);
`endif
    end
    next_cycle();
    rst_n   = 1'b1;
    start   = 1'b0;
    stall_v = 1'b0;
    repeat (5) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 64, number of compression rounds per block; legal range 2..64.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request to process i_block; accepted only while o_ready=1.
REQ-005 i_block  input  512  message block; bits [511:480] = W0 ... [31:0] = W15.
REQ-006 i_new_word  input  32  next schedule word computed by the adder datapath from o_words.
REQ-007 o_words  output  512  schedule window to the adder datapath; 32-bit slot k = bits [32k+31:32k].
REQ-008 o_round  output  6  current round index t, also the K-constant ROM address.
REQ-009 o_ready  output  1  idle and able to accept i_start.
REQ-010 o_load_state  output  1  one-cycle strobe: load working variables a..h from hash state H.
REQ-011 o_round_en  output  1  working variables update this cycle using slot 15 as W_t.
REQ-012 o_final  output  1  one-cycle strobe: H <= H + a..h.
REQ-013 o_done  output  1  one-cycle pulse: block complete, H valid.

Function
REQ-014 FSM states IDLE, LOAD, ROUND, FINAL, DONE; exactly one active.
REQ-015 IDLE: o_ready=1; i_start=1 -> LOAD; i_start=0 -> stay.
REQ-016 i_start while not IDLE is ignored and not queued.
REQ-017 On the cycle i_start is accepted, window captures i_block unchanged (slot 15 = W0, slot 0 = W15); o_round <= 0.
REQ-018 LOAD lasts one cycle with o_load_state=1; next state ROUND.
REQ-019 ROUND: o_round_en=1; each cycle window shifts toward slot 15 (slot k+1 <= slot k, slot 0 <= i_new_word) and o_round increments by 1.
REQ-020 Slot usage by the datapath: slot 15 = W_t / W_t-16 term, slot 14 = W_t+1 (sigma0 input), slot 6 = W_t+9, slot 1 = W_t+14 (sigma1 input).
REQ-021 ROUND exits to FINAL after the cycle with o_round = ROUNDS-1; o_round holds ROUNDS-1 through FINAL and DONE, never wraps past it.
REQ-022 FINAL: o_final=1 for one cycle; next state DONE.
REQ-023 DONE: o_done=1 for one cycle; next state IDLE; o_ready rises the following cycle.
REQ-024 Latency with ROUNDS=64: accept at cycle 0, LOAD cycle 1, rounds cycles 2..65, FINAL 66, DONE 67, o_ready=1 at 68.
REQ-025 o_load_state, o_round_en, o_final, o_done mutually exclusive; all 0 in IDLE.
REQ-026 Window and o_round hold value in IDLE, LOAD, FINAL, DONE (except capture in REQ-017).

Reset
REQ-027 i_rst_n low at any time (incl. mid-ROUND) forces immediately: state IDLE, o_words=0, o_round=0, o_ready=1, all strobes 0.
REQ-028 Operation interrupted by reset is abandoned; no o_final or o_done emitted for it.
REQ-029 After deassertion, first accepted i_start behaves exactly as REQ-017.

Configuration
REQ-030 Macro SHA_ROUND_STALL_EN adds input i_stall (1 bit).
REQ-031 With SHA_ROUND_STALL_EN: i_stall=1 in ROUND or FINAL freezes state, window, o_round, and forces o_round_en=0 and o_final=0 that cycle; no effect in IDLE, LOAD, DONE.
REQ-032 Without SHA_ROUND_STALL_EN: port absent; behaviour equals i_stall tied 0.

Verification
REQ-033 Reset, no start -> o_ready=1, o_words=0, o_round=0, no strobes for 100 cycles.
REQ-034 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), i_new_word from reference schedule model -> cycle 1 slot15=0x61626380; each ROUND cycle slot15 equals model W_t for t=0..63; o_done at cycle 67.
REQ-035 i_start held high continuously -> blocks accepted at cycles 0, 68, 136; exactly one o_done per block.
REQ-036 i_rst_n pulsed low at o_round=30 -> same cycle IDLE, o_words=0; no o_final/o_done; fresh start completes normally.
REQ-037 SHA_ROUND_STALL_EN, i_stall high 5 cycles at o_round=10 -> o_round holds 10, o_round_en=0 during stall; o_done at cycle 72.
REQ-038 ROUNDS=2 -> o_round_en on cycles 2..3 with o_round 0,1; o_final cycle 4; o_done cycle 5.
